// File: rtl/matrix_pkg.sv
// Shared widths, sync byte default and transmit FSM encoding for the matrix
// multiplier result path.
package matrix_pkg;

    localparam int RESULT_W = 10;
    localparam int TX_W     = 8;
    localparam int SEQ_W    = 4;

    localparam logic [TX_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO; dout shows the head entry combinationally and the
// flags depend on registered state only.
module result_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/matrix_result_tx.sv
// Buffers 10-bit results and sends each as a SYNC/LO/HI byte frame with a
// 4-bit sequence tag and a sticky overflow flag for dropped results.
module matrix_result_tx
    import matrix_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] res_data,
    input  logic       res_valid,
    output logic       res_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [SEQ_W-1:0]      seq;
    logic [TX_W-1:0]       data_nxt;
    logic [RESULT_W-1:0]   head;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;
    logic                  hs;

    assign res_ready = ~full;
    assign push      = res_valid & ~full;
    assign hs        = tx_valid & tx_ready;
    assign pop       = (state == ST_HI) & hs;
    assign busy      = (state != ST_IDLE) | ~empty;

    result_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (res_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // The next byte is chosen one cycle early so tx_data/tx_valid leave a register.
    always_comb begin
        state_nxt = state;
        data_nxt  = tx_data;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_nxt = ST_SYNC;
                    data_nxt  = SYNC_BYTE;
                end
            end
            ST_SYNC: begin
                if (hs) begin
                    state_nxt = ST_LO;
                    data_nxt  = head[7:0];
                end
            end
            ST_LO: begin
                if (hs) begin
                    state_nxt = ST_HI;
                    data_nxt  = {seq, 2'b00, head[RESULT_W-1 -: 2]};
                end
            end
            ST_HI: begin
                if (hs) begin
                    if (count > CNT_W'(1)) begin
                        state_nxt = ST_SYNC;
                        data_nxt  = SYNC_BYTE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            seq      <= '0;
        end else begin
            state    <= state_nxt;
            tx_valid <= (state_nxt != ST_IDLE);
            tx_data  <= data_nxt;
            if (pop) begin
                seq <= seq + 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (res_valid && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_result_tx.sv
// Bench for matrix_result_tx: queue-based frame model checked every cycle,
// plus directed frames with hand-computed bytes.
module tb_matrix_result_tx;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] res_data = '0;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model state
    int         m_count;
    bit         m_ovf;
    int         m_accepted;
    int         m_hs_idx;
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    int         log_cyc[$];
    bit         prev_stall;
    logic [7:0] prev_data;

    matrix_result_tx #(
        .SYNC_BYTE  (8'hA5),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: checks outputs, then advances the model across the coming edge.
    always @(negedge clk) begin
        bit pop_e;
        bit push_e;
        bit drop_e;
        pop_e  = 1'b0;
        push_e = 1'b0;
        drop_e = 1'b0;
        if (!rst_n) begin
            check("rst_tx_valid", 32'(tx_valid), 32'(0));
            check("rst_tx_data", 32'(tx_data), 32'(0));
            check("rst_res_ready", 32'(res_ready), 32'(1));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_overflow", 32'(overflow), 32'(0));
            m_count    = 0;
            m_ovf      = 1'b0;
            m_accepted = 0;
            m_hs_idx   = 0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            check("res_ready", 32'(res_ready), 32'(m_count < DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("busy", 32'(busy), 32'(m_count != 0));
            if (m_count == 0) check("idle_valid", 32'(tx_valid), 32'(0));
            if (prev_stall) begin
                check("hold_valid", 32'(tx_valid), 32'(1));
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                log_q.push_back(tx_data);
                log_cyc.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %0h, expected no byte (cycle %0d)", tx_data, cyc);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %0h, expected %0h (cycle %0d)", tx_data, e, cyc);
                    end
                end
                if (m_hs_idx == 2) begin
                    m_hs_idx = 0;
                    pop_e    = 1'b1;
                end else begin
                    m_hs_idx++;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (res_valid) begin
                if (m_count < DEPTH) begin
                    push_e = 1'b1;
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(res_data[7:0]);
                    exp_q.push_back({4'(m_accepted % 16), 2'b00, res_data[9:8]});
                    m_accepted++;
                end else begin
                    drop_e = 1'b1;
                end
            end
            if (drop_e) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_count = m_count + int'(push_e) - int'(pop_e);
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        res_valid = 1'b0;
        clr_ovf   = 1'b0;
        tx_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic push_word(input logic [9:0] w);
        res_valid = 1'b1;
        res_data  = w;
        @(posedge clk);
        #1 res_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || tx_valid) && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        check("drain_busy", 32'(busy), 32'(0));
        check("drain_queue", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic wait_log(input int sz);
        int n;
        n = 0;
        while (log_q.size() < sz && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        check("wait_log", 32'(log_q.size() >= sz), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe;
        int acc;
        int n;
        logic [9:0] w[3];

        // Single frame: 2B7 -> A5 B7 02, first byte one cycle after the push edge
        do_reset();
        push_word(10'h2B7);
        pe = cyc;
        drain();
        check("t1_len", 32'(log_q.size()), 32'(3));
        check("t1_b0", 32'(log_q[0]), 32'(8'hA5));
        check("t1_b1", 32'(log_q[1]), 32'(8'hB7));
        check("t1_b2", 32'(log_q[2]), 32'(8'h02));
        check("t1_lat", 32'(log_cyc[0]), 32'(pe + 1));
        check("t1_span", 32'(log_cyc[2] - log_cyc[0]), 32'(2));

        // Back-to-back frames with seq 0 then 1
        do_reset();
        res_valid = 1'b1;
        res_data  = 10'h3FF;
        @(posedge clk);
        #1 res_data = 10'h001;
        @(posedge clk);
        #1 res_valid = 1'b0;
        drain();
        check("t2_len", 32'(log_q.size()), 32'(6));
        check("t2_b2", 32'(log_q[2]), 32'(8'h03));
        check("t2_b3", 32'(log_q[3]), 32'(8'hA5));
        check("t2_b4", 32'(log_q[4]), 32'(8'h01));
        check("t2_b5", 32'(log_q[5]), 32'(8'h10));
        check("t2_nogap", 32'(log_cyc[5] - log_cyc[0]), 32'(5));

        // Backpressure during LO
        do_reset();
        push_word(10'h155);
        wait_log(1);
        tx_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 check("t3_stall_valid", 32'(tx_valid), 32'(1));
            check("t3_stall_data", 32'(tx_data), 32'(8'h55));
        end
        tx_ready = 1'b1;
        drain();
        check("t3_len", 32'(log_q.size()), 32'(3));
        check("t3_b1", 32'(log_q[1]), 32'(8'h55));
        check("t3_b2", 32'(log_q[2]), 32'(8'h01));

        // Overflow with a stalled link, then set-wins and clear
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) w[i] = 10'($urandom);
        res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_data = w[i];
            @(posedge clk);
            #1 if (i == 1) check("t4_full", 32'(res_ready), 32'(0));
        end
        res_valid = 1'b0;
        check("t4_ovf_set", 32'(overflow), 32'(1));
        res_valid = 1'b1;
        clr_ovf   = 1'b1;
        @(posedge clk);
        #1 res_valid = 1'b0;
        clr_ovf = 1'b0;
        check("t4_set_wins", 32'(overflow), 32'(1));
        clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        check("t4_clear", 32'(overflow), 32'(0));
        tx_ready = 1'b1;
        drain();
        check("t4_len", 32'(log_q.size()), 32'(6));
        check("t4_w0", 32'(log_q[1]), 32'(w[0][7:0]));
        check("t4_w1", 32'(log_q[4]), 32'(w[1][7:0]));

        // Sequence wrap over 17 frames
        do_reset();
        acc = 0;
        n   = 0;
        while (acc < 17 && n < 500) begin
            res_valid = 1'b1;
            res_data  = 10'($urandom);
            if (res_ready) acc++;
            @(posedge clk);
            #1 n++;
        end
        res_valid = 1'b0;
        drain();
        for (int k = 0; k < 17; k++)
            check("t5_seq", 32'(log_q[3*k+2][7:4]), 32'(k % 16));

        // Reset in the middle of a frame
        do_reset();
        push_word(10'h123);
        wait_log(1);
        #2 rst_n = 1'b0;
        #1 check("t6_async_valid", 32'(tx_valid), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        log_q.delete();
        log_cyc.delete();
        push_word(10'h0AA);
        drain();
        check("t6_len", 32'(log_q.size()), 32'(3));
        check("t6_b0", 32'(log_q[0]), 32'(8'hA5));
        check("t6_b1", 32'(log_q[1]), 32'(8'hAA));
        check("t6_b2", 32'(log_q[2]), 32'(8'h00));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            res_valid = ($urandom_range(0, 99) < 40);
            res_data  = 10'($urandom);
            tx_ready  = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
        clr_ovf   = 1'b0;
        tx_ready  = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
